// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Single-cycle logic and shift
// ops complete in one cycle; multu runs an iterative shift-add multiply, one bit per clock.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       o_dbg_state
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready; a result
  // transfers on a rising edge where out_valid && out_ready. Results hold until taken.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic               r_zero;
  logic               r_illegal;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;

  logic [WIDTH-1:0]   w_res;
  logic               w_ill;
  logic               w_is_mul;
  logic               w_slt;
  logic               w_sltu;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  always_comb begin
    w_res    = '0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (alu_op)
      2'b00: w_res = a + b;
      2'b01: w_res = a - b;
      2'b10: begin
        case (funct)
          6'b100000: w_res = a + b;
          6'b100010: w_res = a - b;
          6'b100100: w_res = a & b;
          6'b100101: w_res = a | b;
          6'b100110: w_res = a ^ b;
          6'b100111: w_res = ~(a | b);
          6'b101010: w_res = {{(WIDTH-1){1'b0}}, w_slt};
          6'b101011: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
          6'b000000: w_res = b << shamt;
          6'b000010: w_res = b >> shamt;
          6'b000011: w_res = $signed(b) >>> shamt;
          6'b011001: w_is_mul = 1'b1;
          default:   w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Product register holds {partial_sum, remaining_multiplier}; each step conditionally adds
  // the multiplicand into the upper half and shifts the whole thing right by one.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  assign w_last     = (r_cnt == SHW'(WIDTH-1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_hi      <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_mcand   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_is_mul) begin
          r_prod  <= {{WIDTH{1'b0}}, b};
          r_mcand <= a;
          r_cnt   <= '0;
        end else begin
          r_result  <= w_res;
          r_hi      <= '0;
          r_zero    <= (w_res == '0);
          r_illegal <= w_ill;
        end
      end else if (r_state == S_MUL) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt + 1'b1;
        if (w_last) begin
          r_result  <= w_prod_nxt[WIDTH-1:0];
          r_hi      <= w_prod_nxt[2*WIDTH-1:WIDTH];
          r_zero    <= (w_prod_nxt[WIDTH-1:0] == '0);
          r_illegal <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign hi          = r_hi;
  assign zero        = r_zero;
  assign illegal     = r_illegal;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WIDTH=32): directed literal cases plus randomized traffic with
// random backpressure, checked every cycle against a transaction-level model.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    alu_op = '0;
  logic [5:0]    funct = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [4:0]    shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic [W-1:0]  hi;
  logic          zero;
  logic          illegal;
  logic [1:0]    o_dbg_state;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .hi(hi),
    .zero(zero), .illegal(illegal), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit rdy_mode = 1'b0;

  // ---------------- scoreboard ----------------
  // exp_q entry = {illegal, hi, result}; rdy_q = cycle from which out_valid is expected.
  logic [2*W:0] exp_q[$];
  int           rdy_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [1:0] op, input logic [5:0] f,
                                         input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [4:0] sh, output bit is_mul);
    logic [W-1:0]   r;
    logic [W-1:0]   m;
    logic [2*W-1:0] p;
    bit             ill;
    r = '0; ill = 1'b0; is_mul = 1'b0;
    if (op == 2'd0) r = x + y;
    else if (op == 2'd1) r = x - y;
    else if (op == 2'd3) ill = 1'b1;
    else begin
      case (f)
        6'b100000: r = x + y;
        6'b100010: r = x - y;
        6'b100100: r = x & y;
        6'b100101: r = x | y;
        6'b100110: r = x ^ y;
        6'b100111: r = ~(x | y);
        6'b101010: r = (x[W-1] != y[W-1]) ? W'(x[W-1]) : W'(x < y);
        6'b101011: r = W'(x < y);
        6'b000000: r = y << sh;
        6'b000010: r = y >> sh;
        6'b000011: begin
          m = {W{1'b1}} >> sh;
          r = (y >> sh) | (y[W-1] ? ~m : '0);
        end
        6'b011001: is_mul = 1'b1;
        default:   ill = 1'b1;
      endcase
    end
    if (is_mul) begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return {1'b0, p};
    end
    return {ill, {W{1'b0}}, r};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      bit           ev;
      bit           eir;
      logic [2*W:0] e;
      ev  = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      eir = (exp_q.size() == 0) ? 1'b1 : ((rdy_q[0] > cyc) ? 1'b0 : out_ready);
      check("out_valid", 64'(out_valid), 64'(ev));
      check("in_ready", 64'(in_ready), 64'(eir));
      if (ev && out_valid) begin
        e = exp_q[0];
        check("result", 64'(result), 64'(e[W-1:0]));
        check("hi", 64'(hi), 64'(e[2*W-1:W]));
        check("zero", 64'(zero), 64'(e[W-1:0] == '0));
        check("illegal", 64'(illegal), 64'(e[2*W]));
      end
      if (ev && out_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
    end
  end

  // random backpressure, applied just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rdy_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [4:0] sh, output int acc);
    bit ok;
    bit is_mul;
    logic [2*W:0] e;
    alu_op = op; funct = f; a = x; b = y; shamt = sh; in_valid = 1'b1;
    acc = -1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!reset && in_ready) begin
        acc = cyc + 1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) begin
      e = model(op, f, x, y, sh, is_mul);
      exp_q.push_back(e);
      rdy_q.push_back(acc + (is_mul ? W : 0));
    end
  endtask

  // Counts falling edges after acceptance until out_valid (1 = single-cycle latency).
  task automatic wait_valid(output int n, output int ir_busy);
    n = 0; ir_busy = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
      if (in_ready) ir_busy++;
    end
    if (n == 0) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [5:0] fl[12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                         6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b011001};

  initial begin
    int acc;
    int n;
    int irb;
    int rel;
    int cnt;
    logic [1:0] op;
    logic [5:0] f;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel = cyc;
    out_ready = 1'b1;

    // slt / sltu with a = -1, b = 1; also first accept right after reset release
    send(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, acc);
    check("first_accept_edge", 64'(acc), 64'(rel + 1));
    wait_valid(n, irb);
    check("slt_latency", 64'(n), 64'd1);
    check("slt_result", 64'(result), 64'd1);
    check("slt_zero", 64'(zero), 64'd0);
    tick();
    send(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0, acc);
    wait_valid(n, irb);
    check("sltu_result", 64'(result), 64'd0);
    check("sltu_zero", 64'(zero), 64'd1);
    tick();

    // arithmetic vs logical right shift
    send(2'b10, 6'b000011, 32'd0, 32'h8000_0000, 5'd4, acc);
    wait_valid(n, irb);
    check("sra_result", 64'(result), 64'hF800_0000);
    tick();
    send(2'b10, 6'b000010, 32'd0, 32'h8000_0000, 5'd4, acc);
    wait_valid(n, irb);
    check("srl_result", 64'(result), 64'h0800_0000);
    tick();

    // multu of all-ones operands
    send(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, acc);
    wait_valid(n, irb);
    check("mul_latency", 64'(n), 64'd33);
    check("mul_in_ready_busy", 64'(irb), 64'd0);
    check("mul_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul_lo", 64'(result), 64'h0000_0001);
    tick();

    // hold in DONE under backpressure, then back-to-back add
    out_ready = 1'b0;
    send(2'b00, 6'b000000, 32'd10, 32'd20, 5'd0, acc);
    wait_valid(n, irb);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", 64'(result), 64'd30);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    tick();
    out_ready = 1'b1;
    send(2'b00, 6'b000000, 32'd2, 32'd3, 5'd0, acc);
    wait_valid(n, irb);
    check("b2b_latency", 64'(n), 64'd1);
    check("b2b_result", 64'(result), 64'd5);
    tick();

    // reset during the 10th cycle of a multiply
    send(2'b10, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, acc);
    repeat (9) tick();
    reset = 1'b1;
    exp_q.delete();
    rdy_q.delete();
    #1;
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("aborted_mul_silent", 64'(cnt), 64'd0);
    tick();
    send(2'b00, 6'b000000, 32'd7, 32'd8, 5'd0, acc);
    wait_valid(n, irb);
    check("post_rst_add", 64'(result), 64'd15);
    tick();

    // illegal operations
    send(2'b11, 6'b100000, 32'd5, 32'd6, 5'd0, acc);
    wait_valid(n, irb);
    check("ill_op_latency", 64'(n), 64'd1);
    check("ill_op_flag", 64'(illegal), 64'd1);
    check("ill_op_result", 64'(result), 64'd0);
    check("ill_op_zero", 64'(zero), 64'd1);
    tick();
    send(2'b10, 6'b111111, 32'd5, 32'd6, 5'd0, acc);
    wait_valid(n, irb);
    check("ill_funct_latency", 64'(n), 64'd1);
    check("ill_funct_flag", 64'(illegal), 64'd1);
    check("ill_funct_result", 64'(result), 64'd0);
    check("ill_funct_zero", 64'(zero), 64'd1);
    tick();

    // randomized traffic with random backpressure
    rdy_mode = 1'b1;
    for (int t = 0; t < 300; t++) begin
      cnt = $urandom_range(0, 15);
      if (cnt == 0) op = 2'd3;
      else if (cnt <= 2) op = 2'd0;
      else if (cnt <= 3) op = 2'd1;
      else op = 2'd2;
      f = ($urandom_range(0, 19) < 18) ? fl[$urandom_range(0, 11)] : 6'($urandom);
      send(op, f, rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)), acc);
      repeat ($urandom_range(0, 2)) tick();
    end

    // drain
    rdy_mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), SHALL set the shift-amount width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  SHALL mark an operation offered on alu_op/funct/a/b/shamt.
REQ-006 Port in_ready  output  1  SHALL indicate the unit accepts an operation this cycle.
REQ-007 Port alu_op  input  2  SHALL be the main-decoder ALU operation class.
REQ-008 Port funct  input  6  SHALL be the R-type function field.
REQ-009 Ports a, b  input  WIDTH  SHALL be operands (a = rs, b = rt).
REQ-010 Port shamt  input  SHW  SHALL be the shift amount.
REQ-011 Port out_valid  output  1  SHALL mark a valid result.
REQ-012 Port out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-013 Port result  output  WIDTH  SHALL be the primary result (LO for multiply).
REQ-014 Port hi  output  WIDTH  SHALL be the multiply upper half; 0 for all other ops.
REQ-015 Port zero  output  1  SHALL be 1 when result == 0.
REQ-016 Port illegal  output  1  SHALL flag an undecodable operation, valid with out_valid.

Function
REQ-017 Decode SHALL be: alu_op 00 add; 01 sub (a-b); 10 by funct; 11 illegal.
REQ-018 funct map SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt signed, 101011 sltu, 000000 sll b, 000010 srl b, 000011 sra b, 011001 multu; any other funct illegal.
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH; no overflow signalling.
REQ-020 slt/sltu SHALL return 1 or 0 zero-extended to WIDTH.
REQ-021 Shifts SHALL shift b by shamt; sra SHALL replicate b[WIDTH-1].
REQ-022 Illegal ops SHALL produce result=0, hi=0, zero=1, illegal=1, with normal single-cycle timing.
REQ-023 FSM states SHALL be IDLE, MUL, DONE.
REQ-024 Acceptance SHALL occur on a rising edge with in_valid && in_ready; operands latched at that edge.
REQ-025 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-026 Non-multiply op accepted: next state DONE; out_valid=1 from the acceptance edge (latency 1).
REQ-027 multu accepted: next state MUL, iteration counter = 0; unsigned shift-add, one multiplier bit per edge.
REQ-028 MUL SHALL run exactly WIDTH iteration edges, then enter DONE with {hi,result} = a*b (2*WIDTH-bit product); out_valid rises after edge WIDTH+0 counting from acceptance edge = edge 0 (latency WIDTH+1).
REQ-029 In MUL, in_ready=0, out_valid=0; in_valid ignored.
REQ-030 In DONE, result/hi/zero/illegal SHALL hold stable until out_valid && out_ready.
REQ-031 DONE with out_ready=1 and no new acceptance SHALL go to IDLE; with simultaneous acceptance SHALL load the new op (back-to-back, no bubble for single-cycle ops).
REQ-032 out_valid SHALL be 0 in IDLE and MUL, 1 in DONE.

Reset
REQ-033 reset=1 SHALL immediately force state IDLE, out_valid=0, result=0, hi=0, zero=1, illegal=0, counter=0.
REQ-034 reset asserted mid-MUL SHALL abort the multiply; no result is ever presented for it.
REQ-035 First acceptance possible on the first rising edge after reset deasserts.

Verification (WIDTH=32)
REQ-036 alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1, zero=0, out_valid 1 cycle after accept; funct=101011 same operands -> result=0, zero=1.
REQ-037 funct=000011, b=0x80000000, shamt=4 -> result=0xF8000000; funct=000010 -> 0x08000000.
REQ-038 funct=011001, a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, hi=0xFFFFFFFE, result=0x00000001; in_ready=0 throughout MUL.
REQ-039 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 with in_valid=1 add 2+3 -> next cycle out_valid=1, result=5 (no bubble).
REQ-040 reset pulsed during cycle 10 of a multu -> out_valid=0, in_ready=1 after release; following add 7+8 -> result=15.
REQ-041 alu_op=11, and alu_op=10 funct=111111 -> illegal=1, result=0, zero=1, out_valid after 1 cycle.
